// File: rtl/wb_traffic_pkg.sv
// Shared types and helpers for the Wishbone SDRAM traffic master.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package wb_traffic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT,
        WRITE,
        WR_GAP,
        READ,
        RD_GAP,
        DONE
    } state_t;

    localparam int          ACK_TIMEOUT_DEF = 1024;
    localparam logic [31:0] PAT_STEP_DEF    = 32'h0101_0101;

    // Word i of the test pattern: seed + i*step, wrapping at 2^32.
    function automatic logic [31:0] pat(input logic [31:0] seed,
                                        input logic [31:0] idx,
                                        input logic [31:0] step);
        pat = seed + idx * step;
    endfunction

endpackage

// File: rtl/wb_traffic_pattern_gen.sv
// Address/data generator for word idx of a traffic test (base + 4*idx, pattern word).
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow the inputs, caller holds inputs stable.
module wb_traffic_pattern_gen
    import wb_traffic_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int          CNT_W    = 8,
    parameter logic [31:0] PAT_STEP = PAT_STEP_DEF
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [DATA_W-1:0] seed,
    input  logic [CNT_W-1:0]  idx,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // Byte address advances one 32-bit word per index; data from the shared pattern function.
    always_comb begin
        addr = base + (ADDR_W'(idx) << 2);
        data = DATA_W'(pat(32'(seed), 32'(idx), PAT_STEP));
    end

endmodule

// File: rtl/wb_sdram_traffic_master.sv
// Self-checking Wishbone B4 classic master: write N pattern words, read back, compare.
// Latency: each access is stb until ack plus one idle gap cycle; done 4*N cycles after first stb with a zero-wait slave.
// Backpressure: holds cyc/stb/adr/dat until ack; aborts to DONE after ACK_TIMEOUT stb cycles without ack.
module wb_sdram_traffic_master
    import wb_traffic_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          CNT_W       = 8,
    parameter int          ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter logic [31:0] PAT_STEP    = PAT_STEP_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  num_words_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic              sdr_init_done_i,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [3:0]        wb_sel_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [CNT_W-1:0]  err_count_o,
    output logic              timeout_o
);

    localparam int                TMO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] WORD_MSK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  num_q;
    logic [DATA_W-1:0] seed_q;
    logic [CNT_W-1:0]  idx_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic [CNT_W-1:0]  err_q;
    logic              timeout_q;
    logic              pass_q;

    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic              stb;
    logic              ack_hit;
    logic              tmo_hit;
    logic              mismatch;
    logic              err_inc;
    logic              start_hit;
    logic              last_word;

    wb_traffic_pattern_gen #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .CNT_W    (CNT_W),
        .PAT_STEP (PAT_STEP)
    ) u_pattern_gen (
        .base (base_q),
        .seed (seed_q),
        .idx  (idx_q),
        .addr (cur_addr),
        .data (cur_data)
    );

    // Per-cycle bus events: ack only counts while strobing, timeout fires on the last allowed stb cycle.
    always_comb begin
        stb       = (state_q == WRITE) || (state_q == READ);
        ack_hit   = stb && wb_ack_i;
        tmo_hit   = stb && !wb_ack_i && (tmo_cnt_q == TMO_LAST);
        mismatch  = (state_q == READ) && ack_hit && (wb_dat_i != cur_data);
        err_inc   = mismatch && (err_q != {CNT_W{1'b1}});
        start_hit = (state_q == IDLE) && start_i;
        last_word = (idx_q == num_q);
    end

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = WAIT_INIT;
            end
            WAIT_INIT: begin
                if (sdr_init_done_i) begin
                    if (num_q == '0) state_d = DONE;
                    else             state_d = WRITE;
                end
            end
            WRITE: begin
                if (ack_hit)      state_d = WR_GAP;
                else if (tmo_hit) state_d = DONE;
            end
            WR_GAP: begin
                if (last_word) state_d = READ;
                else           state_d = WRITE;
            end
            READ: begin
                if (ack_hit)      state_d = RD_GAP;
                else if (tmo_hit) state_d = DONE;
            end
            RD_GAP: begin
                if (last_word) state_d = DONE;
                else           state_d = READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Test configuration, word index, ack watchdog and result registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            base_q    <= '0;
            num_q     <= '0;
            seed_q    <= '0;
            idx_q     <= '0;
            tmo_cnt_q <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            if (start_hit) begin
                base_q    <= base_addr_i & WORD_MSK;
                num_q     <= num_words_i;
                seed_q    <= seed_i;
                idx_q     <= '0;
                err_q     <= '0;
                timeout_q <= 1'b0;
                pass_q    <= 1'b0;
            end

            // Index advances per acked word and rewinds between write and read phases.
            if (ack_hit) begin
                idx_q <= idx_q + 1'b1;
            end else if ((state_q == WR_GAP) && last_word) begin
                idx_q <= '0;
            end

            // Watchdog counts stb cycles still waiting for ack.
            if (stb && !wb_ack_i) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end else begin
                tmo_cnt_q <= '0;
            end

            if (err_inc) begin
                err_q <= err_q + 1'b1;
            end

            if (tmo_hit) begin
                timeout_q <= 1'b1;
            end

            // Verdict folds in this edge's error/timeout so it is valid in the DONE cycle.
            if ((state_d == DONE) && (state_q != DONE)) begin
                pass_q <= (err_q == '0) && !err_inc && !timeout_q && !tmo_hit;
            end
        end
    end

    // Bus and status outputs; address/data/we are zero outside a bus cycle.
    always_comb begin
        wb_cyc_o    = stb;
        wb_stb_o    = stb;
        wb_we_o     = (state_q == WRITE);
        wb_sel_o    = stb ? 4'hF : 4'h0;
        wb_adr_o    = stb ? cur_addr : '0;
        wb_dat_o    = (state_q == WRITE) ? cur_data : '0;
        busy_o      = (state_q != IDLE) && (state_q != DONE);
        done_o      = (state_q == DONE);
        pass_o      = pass_q;
        err_count_o = err_q;
        timeout_o   = timeout_q;
    end

endmodule

// File: tb/tb_wb_sdram_traffic_master.sv
// Bench for the Wishbone SDRAM traffic master with a memory-backed Wishbone slave model.
// Latency: slave acks in the first stb cycle unless acks are disabled.
// Backpressure: slave can withhold ack entirely to exercise the master's watchdog.
module tb_wb_sdram_traffic_master;

    localparam logic [31:0] STEP = 32'h0101_0101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base = '0;
    logic [7:0]  num = '0;
    logic [31:0] seed = '0;
    logic        init = 1'b0;

    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [31:0] slv_dat;
    logic        wb_ack;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;
    logic [7:0]  err_count_o;
    logic        timeout_o;

    wb_sdram_traffic_master #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .CNT_W       (8),
        .ACK_TIMEOUT (16),
        .PAT_STEP    (STEP)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .start_i         (start),
        .base_addr_i     (base),
        .num_words_i     (num),
        .seed_i          (seed),
        .sdr_init_done_i (init),
        .wb_cyc_o        (wb_cyc),
        .wb_stb_o        (wb_stb),
        .wb_we_o         (wb_we),
        .wb_sel_o        (wb_sel),
        .wb_adr_o        (wb_adr),
        .wb_dat_o        (wb_dat_o),
        .wb_dat_i        (slv_dat),
        .wb_ack_i        (wb_ack),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .pass_o          (pass_o),
        .err_count_o     (err_count_o),
        .timeout_o       (timeout_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Slave model: zero-wait ack, word memory, optional single-bit corruption per read index.
    logic [31:0] mem [0:255];
    logic        ack_en = 1'b1;
    logic [7:0]  corrupt_mask = '0;
    int          rd_cnt = 0;
    int          rd_base = 0;
    int          rd_rel;

    assign wb_ack = wb_stb && ack_en;

    always_comb begin
        rd_rel  = rd_cnt - rd_base;
        slv_dat = mem[wb_adr[9:2]];
        if (rd_rel >= 0 && rd_rel < 8) begin
            if (corrupt_mask[rd_rel[2:0]]) slv_dat = slv_dat ^ 32'h0000_0001;
        end
    end

    always @(posedge clk) begin
        if (wb_cyc && wb_stb && wb_ack) begin
            if (wb_we) mem[wb_adr[9:2]] <= wb_dat_o;
            else       rd_cnt <= rd_cnt + 1;
        end
    end

    // Scoreboard of expected bus transactions, filled when a test is launched.
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    txn_t exp_q[$];

    task automatic push_expected(input logic [31:0] b, input logic [7:0] n, input logic [31:0] s);
        txn_t        t;
        logic [31:0] ab;
        ab = b & 32'hFFFF_FFFC;
        for (int i = 0; i < n; i++) begin
            t.we = 1'b1; t.adr = ab + 32'(i) * 4; t.dat = s + 32'(i) * STEP;
            exp_q.push_back(t);
        end
        for (int i = 0; i < n; i++) begin
            t.we = 1'b0; t.adr = ab + 32'(i) * 4; t.dat = '0;
            exp_q.push_back(t);
        end
    endtask

    // Bus monitor: idle-bus values, sel, stability while waiting, and acked transactions.
    logic        prev_pend = 1'b0;
    logic [31:0] prev_adr = '0;
    logic [31:0] prev_dat = '0;
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        txn_t e;
        if (!wb_cyc) begin
            chk("idle_ctl", {59'd0, wb_stb, wb_we, wb_sel}, 64'd0);
            chk("idle_adr", {32'd0, wb_adr}, 64'd0);
            chk("idle_dat", {32'd0, wb_dat_o}, 64'd0);
        end else begin
            chk("sel_full", {60'd0, wb_sel}, 64'hF);
            if (prev_pend) begin
                chk("hold_stable", {wb_adr, wb_dat_o ^ {31'd0, wb_we}},
                                   {prev_adr, prev_dat ^ {31'd0, prev_we}});
            end
            if (wb_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: unexpected txn adr=%0h we=%0b", wb_adr, wb_we);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_we", {63'd0, wb_we}, {63'd0, e.we});
                    chk("sb_adr", {32'd0, wb_adr}, {32'd0, e.adr});
                    if (e.we) chk("sb_dat", {32'd0, wb_dat_o}, {32'd0, e.dat});
                end
            end
        end
        prev_pend <= wb_stb && !wb_ack;
        prev_adr  <= wb_adr;
        prev_dat  <= wb_dat_o;
        prev_we   <= wb_we;
    end

    task automatic do_start(input logic [31:0] b, input logic [7:0] n, input logic [31:0] s);
        @(posedge clk); #1;
        base = b; num = n; seed = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, output bit seen, output int stb_n,
                                  output int first_stb, output int done_at);
        seen = 1'b0; stb_n = 0; first_stb = -1; done_at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (wb_stb) begin
                stb_n++;
                if (first_stb < 0) first_stb = k;
            end
            if (done_o) begin
                seen = 1'b1;
                done_at = k;
                break;
            end
        end
    endtask

    typedef struct {
        logic [31:0] base;
        logic [7:0]  n;
        logic [31:0] seed;
        logic [7:0]  cmask;
        logic [7:0]  exp_err;
        logic        exp_pass;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int stb_n, fs, da, cyc_n;
        bit found;

        vecs[0] = '{32'h0000_0100, 8'd4, 32'hA5A5_0000, 8'h00, 8'd0, 1'b1};
        vecs[1] = '{32'h0000_0100, 8'd4, 32'hA5A5_0000, 8'h04, 8'd1, 1'b0};
        vecs[2] = '{32'hFFFF_FFF8, 8'd4, 32'hFFFF_FFFF, 8'h00, 8'd0, 1'b1};
        vecs[3] = '{32'h0000_0203, 8'd3, 32'h0000_0000, 8'h07, 8'd3, 1'b0};
        vecs[4] = '{32'h0000_0040, 8'd1, 32'h1234_5678, 8'h00, 8'd0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {52'd0, wb_cyc, wb_stb, wb_we, wb_sel, busy_o, done_o, pass_o, timeout_o},
                         64'd0);
        chk("reset_err", {56'd0, err_count_o}, 64'd0);
        #1 rst = 1'b0;
        init = 1'b1;

        // Table-driven full tests with a zero-wait slave
        for (int t = 0; t < 5; t++) begin
            corrupt_mask = vecs[t].cmask;
            rd_base = rd_cnt;
            exp_q.delete();
            push_expected(vecs[t].base, vecs[t].n, vecs[t].seed);
            do_start(vecs[t].base, vecs[t].n, vecs[t].seed);
            run_until_done(300, seen, stb_n, fs, da);
            chk($sformatf("t%0d_done_seen", t), {63'd0, seen}, 64'd1);
            chk($sformatf("t%0d_stb_to_done", t), 64'(da - fs), 64'(4 * int'(vecs[t].n)));
            chk($sformatf("t%0d_stb_cycles", t), 64'(stb_n), 64'(2 * int'(vecs[t].n)));
            chk($sformatf("t%0d_pass", t), {63'd0, pass_o}, {63'd0, vecs[t].exp_pass});
            chk($sformatf("t%0d_err", t), {56'd0, err_count_o}, {56'd0, vecs[t].exp_err});
            chk($sformatf("t%0d_tmo_busy", t), {62'd0, timeout_o, busy_o}, 64'd0);
            @(negedge clk);
            chk($sformatf("t%0d_done_pulse", t), {63'd0, done_o}, 64'd0);
            chk($sformatf("t%0d_pass_sticky", t), {63'd0, pass_o}, {63'd0, vecs[t].exp_pass});
            chk($sformatf("t%0d_sb_drained", t), 64'(exp_q.size()), 64'd0);
        end
        corrupt_mask = '0;

        // N=0: no bus cycle, done two cycles after start, pass
        exp_q.delete();
        do_start(32'h0000_0500, 8'd0, 32'h1);
        @(negedge clk);
        chk("n0_first", {60'd0, done_o, busy_o, pass_o, wb_cyc}, 64'b0100);
        @(negedge clk);
        chk("n0_done", {60'd0, done_o, busy_o, pass_o, wb_cyc}, 64'b1010);
        chk("n0_err_tmo", {55'd0, err_count_o, timeout_o}, 64'd0);

        // Slave never acks: stb held ACK_TIMEOUT cycles, then abort
        ack_en = 1'b0;
        exp_q.delete();
        do_start(32'h0000_0000, 8'd2, 32'h55);
        run_until_done(100, seen, stb_n, fs, da);
        chk("tmo_done_seen", {63'd0, seen}, 64'd1);
        chk("tmo_stb_cycles", 64'(stb_n), 64'd16);
        chk("tmo_flags", {61'd0, timeout_o, pass_o, wb_cyc}, 64'b100);
        @(negedge clk);
        chk("tmo_sticky", {62'd0, timeout_o, done_o}, 64'b10);
        ack_en = 1'b1;

        // Wait for SDRAM init; a second start meanwhile is ignored
        init = 1'b0;
        rd_base = rd_cnt;
        exp_q.delete();
        push_expected(32'h0000_0600, 8'd2, 32'hC0DE_0000);
        do_start(32'h0000_0600, 8'd2, 32'hC0DE_0000);
        cyc_n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (wb_cyc) cyc_n++;
            if (k == 50) begin
                start = 1'b1; base = 32'h0000_0700; num = 8'd5;
            end
            if (k == 51) start = 1'b0;
        end
        chk("init_no_cyc", 64'(cyc_n), 64'd0);
        chk("init_busy", {63'd0, busy_o}, 64'd1);
        init = 1'b1;
        run_until_done(100, seen, stb_n, fs, da);
        chk("init_done_seen", {63'd0, seen}, 64'd1);
        chk("init_stb_cycles", 64'(stb_n), 64'd4);
        chk("init_pass", {63'd0, pass_o}, 64'd1);
        chk("init_sb_drained", 64'(exp_q.size()), 64'd0);

        // Reset while a read strobe is active
        rd_base = rd_cnt;
        exp_q.delete();
        push_expected(32'h0000_0800, 8'd4, 32'h77);
        do_start(32'h0000_0800, 8'd4, 32'h77);
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (wb_stb && !wb_we) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_read_found", {63'd0, found}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_drop", {57'd0, wb_cyc, wb_stb, busy_o, done_o, pass_o, timeout_o, wb_we}, 64'd0);
        chk("rst_err", {56'd0, err_count_o}, 64'd0);
        rst = 1'b0;
        cyc_n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (wb_cyc || busy_o || done_o || pass_o) cyc_n++;
        end
        chk("rst_stays_idle", 64'(cyc_n), 64'd0);
        exp_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
